// File: rtl/ttrng_byte_collector.sv
// TRNG byte collector: von Neumann debias, MSB-first byte packing, byte FIFO with read-strobe handshake.
// Optional repetition-count health test enabled by defining TTRNG_HEALTH_EN.
module ttrng_byte_collector #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned RCT_LIMIT  = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        ena,
    input  logic                        raw_bit,
    input  logic                        raw_valid,
    input  logic                        rd_req,
    output logic [7:0]                  data_out,
    output logic                        data_valid,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        overflow,
    output logic                        health_fail
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || RCT_LIMIT < 2) begin : g_bad_param
        $error("ttrng_byte_collector: illegal FIFO_DEPTH or RCT_LIMIT");
    end

    typedef enum logic {
        WAIT_A = 1'b0,
        WAIT_B = 1'b1
    } pair_state_t;

    pair_state_t state, state_nxt;
    logic        a_q;
    logic        adv_c;
    logic        emit_c;
    logic        emit_bit_c;

    logic [6:0]  sr;
    logic [2:0]  bit_cnt;
    logic        byte_done_c;
    logic [7:0]  new_byte_c;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level;
    logic             full_c;
    logic             pop_c;
    logic             push_c;
    logic             push_ok_c;
    logic             push_blk_c;

    assign adv_c = ena & raw_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= WAIT_A;
            a_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (adv_c && state == WAIT_A) begin
                a_q <= raw_bit;
            end
        end
    end

    // Pair extractor: 10 -> 1, 01 -> 0, equal pairs discarded.
    always_comb begin
        state_nxt  = state;
        emit_c     = 1'b0;
        emit_bit_c = a_q;
        if (adv_c) begin
            case (state)
                WAIT_A: state_nxt = WAIT_B;
                WAIT_B: begin
                    state_nxt = WAIT_A;
                    emit_c    = (raw_bit != a_q);
                end
                default: state_nxt = WAIT_A;
            endcase
        end
    end

    assign new_byte_c  = {sr, emit_bit_c};
    assign byte_done_c = emit_c && (bit_cnt == 3'd7);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr      <= 7'd0;
            bit_cnt <= 3'd0;
        end else if (emit_c) begin
            sr      <= new_byte_c[6:0];
            bit_cnt <= bit_cnt + 3'd1;
        end
    end

`ifdef TTRNG_HEALTH_EN
    localparam int unsigned RUN_W = $clog2(RCT_LIMIT + 1);

    logic [RUN_W-1:0] run_len;
    logic [RUN_W-1:0] run_nxt_c;
    logic             last_raw;

    // Run length saturates at the limit; a fresh run starts at 1.
    always_comb begin
        run_nxt_c = RUN_W'(1);
        if (run_len != '0 && raw_bit == last_raw) begin
            run_nxt_c = (run_len == RUN_W'(RCT_LIMIT)) ? run_len : run_len + RUN_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_len     <= '0;
            last_raw    <= 1'b0;
            health_fail <= 1'b0;
        end else if (adv_c) begin
            run_len  <= run_nxt_c;
            last_raw <= raw_bit;
            if (run_nxt_c == RUN_W'(RCT_LIMIT)) begin
                health_fail <= 1'b1;
            end
        end
    end

    assign push_blk_c = health_fail;
`else
    assign health_fail = 1'b0;
    assign push_blk_c  = 1'b0;
`endif

    assign full_c    = (level == LVL_W'(FIFO_DEPTH));
    assign pop_c     = ena & rd_req & (level != '0);
    assign push_c    = byte_done_c & ~push_blk_c;
    assign push_ok_c = push_c & (~full_c | pop_c);

    // Byte FIFO; a push into a full FIFO survives only when a pop frees the slot at the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem[i] <= 8'd0;
            end
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok_c) begin
                mem[wr_ptr] <= new_byte_c;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok_c, pop_c})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
            if (push_c && full_c && !pop_c) begin
                overflow <= 1'b1;
            end
        end
    end

    assign data_out   = mem[rd_ptr];
    assign data_valid = (level != '0);
    assign fifo_level = level;

endmodule

// File: tb/tb_ttrng_byte_collector.sv
// Self-checking bench for ttrng_byte_collector: vector table plus scoreboarded corner sequences.
// Health expectations follow TTRNG_HEALTH_EN when the bench is built with it.
module tb_ttrng_byte_collector;

    localparam int unsigned DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       raw_bit;
    logic       raw_valid;
    logic       rd_req;
    logic [7:0] data_out;
    logic       data_valid;
    logic [2:0] fifo_level;
    logic       overflow;
    logic       health_fail;

    ttrng_byte_collector #(.FIFO_DEPTH(DEPTH), .RCT_LIMIT(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .raw_bit     (raw_bit),
        .raw_valid   (raw_valid),
        .rd_req      (rd_req),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .fifo_level  (fifo_level),
        .overflow    (overflow),
        .health_fail (health_fail)
    );

    always #5 clk = ~clk;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] sb[$];
    logic [6:0] m_sr;
    int         m_cnt;
    bit         m_ovf;
    bit         m_health;
    int         m_run;
    bit         m_last;

    typedef struct {
        logic [7:0] value;
        bit         junk;
        logic [7:0] exp_data;
        logic [2:0] exp_level;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic raw(input bit b, input bit pop);
        raw_bit   = b;
        raw_valid = 1'b1;
        rd_req    = pop;
        @(posedge clk);
        #1;
        raw_valid = 1'b0;
        rd_req    = 1'b0;
        if (m_run > 0 && b == m_last) m_run++;
        else m_run = 1;
        m_last = b;
`ifdef TTRNG_HEALTH_EN
        if (m_run >= 32) m_health = 1'b1;
`endif
    endtask

    // One debiased bit as a pair, optionally preceded by a discarded equal pair.
    task automatic send_bit(input bit b, input bit junk, input bit pop);
        bit         j;
        bit         dp;
        logic [7:0] byt;
        if (junk) begin
            j = 1'($urandom_range(0, 1));
            raw(j, 1'b0);
            raw(j, 1'b0);
        end
        raw(b, 1'b0);
        dp = pop && (sb.size() > 0);
        if (dp) check("pop_head", 32'(data_out), 32'(sb[0]));
        raw(~b, pop);
        if (dp) void'(sb.pop_front());
        byt   = {m_sr, b};
        m_sr  = byt[6:0];
        m_cnt = (m_cnt + 1) % 8;
        if (m_cnt == 0 && !m_health) begin
            if (sb.size() < int'(DEPTH)) sb.push_back(byt);
            else m_ovf = 1'b1;
        end
    endtask

    task automatic send_byte(input logic [7:0] v, input bit junk, input bit pop_last);
        for (int i = 7; i >= 0; i--) begin
            send_bit(v[i], junk, pop_last && (i == 0));
        end
    endtask

    task automatic read_check(input string name);
        check({name, "_valid"}, 32'(data_valid), 32'(sb.size() > 0));
        if (sb.size() > 0) check(name, 32'(data_out), 32'(sb[0]));
        rd_req = 1'b1;
        @(posedge clk);
        #1;
        rd_req = 1'b0;
        if (sb.size() > 0) void'(sb.pop_front());
    endtask

    task automatic check_state(input string name);
        check({name, "_level"}, 32'(fifo_level), 32'(sb.size()));
        check({name, "_valid"}, 32'(data_valid), 32'(sb.size() > 0));
        if (sb.size() > 0) check({name, "_data"}, 32'(data_out), 32'(sb[0]));
        check({name, "_ovf"}, 32'(overflow), 32'(m_ovf));
        check({name, "_health"}, 32'(health_fail), 32'(m_health));
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        ena       = 1'b1;
        raw_valid = 1'b0;
        rd_req    = 1'b0;
        raw_bit   = 1'b0;
        #12;
        sb.delete();
        m_sr     = 7'd0;
        m_cnt    = 0;
        m_ovf    = 1'b0;
        m_health = 1'b0;
        m_run    = 0;
        m_last   = 1'b0;
        check("rst_data", 32'(data_out), 32'h0);
        check("rst_valid", 32'(data_valid), 32'h0);
        check("rst_level", 32'(fifo_level), 32'h0);
        check("rst_ovf", 32'(overflow), 32'h0);
        check("rst_health", 32'(health_fail), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{value: 8'hB1, junk: 1'b0, exp_data: 8'hB1, exp_level: 3'd1};
        vecs[1] = '{value: 8'hB1, junk: 1'b1, exp_data: 8'hB1, exp_level: 3'd1};
        vecs[2] = '{value: 8'h00, junk: 1'b0, exp_data: 8'h00, exp_level: 3'd1};
        vecs[3] = '{value: 8'hFF, junk: 1'b1, exp_data: 8'hFF, exp_level: 3'd1};
        vecs[4] = '{value: 8'h5A, junk: 1'b0, exp_data: 8'h5A, exp_level: 3'd1};
        vecs[5] = '{value: 8'hC3, junk: 1'b1, exp_data: 8'hC3, exp_level: 3'd1};

        do_reset();

        for (int v = 0; v < 6; v++) begin
            send_byte(vecs[v].value, vecs[v].junk, 1'b0);
            check("vec_data", 32'(data_out), 32'(vecs[v].exp_data));
            check("vec_level", 32'(fifo_level), 32'(vecs[v].exp_level));
            check("vec_valid", 32'(data_valid), 32'h1);
            read_check("vec_read");
            check("vec_drained", 32'(fifo_level), 32'h0);
        end

        // Overflow: fifth byte dropped, first four intact.
        for (int k = 1; k <= 5; k++) send_byte(8'(k), 1'b0, 1'b0);
        check("ovf_level", 32'(fifo_level), 32'd4);
        check("ovf_flag", 32'(overflow), 32'h1);
        check("ovf_head", 32'(data_out), 32'h01);
        check_state("ovf_state");
        for (int k = 0; k < 4; k++) read_check("ovf_read");
        read_check("ovf_empty_read");
        check("ovf_empty_level", 32'(fifo_level), 32'h0);
        check("ovf_sticky", 32'(overflow), 32'h1);

        // Full FIFO with push and pop on the same edge.
        do_reset();
        for (int k = 1; k <= 4; k++) send_byte(8'(k), 1'b0, 1'b0);
        check("full_level", 32'(fifo_level), 32'd4);
        send_byte(8'h77, 1'b0, 1'b1);
        check("pp_head", 32'(data_out), 32'h02);
        check("pp_level", 32'(fifo_level), 32'd4);
        check("pp_ovf", 32'(overflow), 32'h0);
        for (int k = 0; k < 4; k++) read_check("pp_read");
        read_check("pp_empty_read");
        check_state("pp_state");

        // ena low freezes everything, including a partial byte.
        send_byte(8'h3C, 1'b0, 1'b0);
        for (int i = 7; i >= 4; i--) send_bit(1'((8'hA5 >> i) & 1), 1'b0, 1'b0);
        ena = 1'b0;
        repeat (20) begin
            raw_valid = 1'($urandom_range(0, 1));
            raw_bit   = 1'($urandom_range(0, 1));
            rd_req    = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        raw_valid = 1'b0;
        rd_req    = 1'b0;
        ena       = 1'b1;
        check("ena_level", 32'(fifo_level), 32'd1);
        check("ena_data", 32'(data_out), 32'h3C);
        for (int i = 3; i >= 0; i--) send_bit(1'((8'hA5 >> i) & 1), 1'b0, 1'b0);
        check("ena_resume_level", 32'(fifo_level), 32'd2);
        read_check("ena_read0");
        check("ena_second", 32'(data_out), 32'hA5);
        read_check("ena_read1");

        // Reset after five debiased bits drops the partial byte.
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0, 1'b0);
        do_reset();
        send_byte(8'h96, 1'b1, 1'b0);
        check("rst_new_data", 32'(data_out), 32'h96);
        check("rst_new_level", 32'(fifo_level), 32'd1);
        read_check("rst_new_read");

        // Repetition health test on 32 consecutive ones.
        do_reset();
        repeat (31) raw(1'b1, 1'b0);
        check("health_31", 32'(health_fail), 32'h0);
        raw(1'b1, 1'b0);
`ifdef TTRNG_HEALTH_EN
        check("health_32", 32'(health_fail), 32'h1);
`else
        check("health_32", 32'(health_fail), 32'h0);
`endif
        send_byte(8'h12, 1'b0, 1'b0);
`ifdef TTRNG_HEALTH_EN
        check("health_block", 32'(fifo_level), 32'h0);
`else
        check("health_block", 32'(fifo_level), 32'h1);
`endif
        check_state("health_state");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ttrng_byte_collector.md
Name: ttrng_byte_collector

Overview:
Consumer end of the TRNG entropy path inside tt_um_ttrng. Takes the raw latch-network bit stream with a qualifier and removes bias with a von Neumann extractor. Packs the debiased bits MSB-first into bytes and buffers them in a small FIFO. The buffered bytes are handed to an external reader over uo_out using a valid/read-strobe handshake on uio.

Parameters:
FIFO_DEPTH, 4, number of byte entries; power of two, minimum 2.
RCT_LIMIT, 32, repetition-count threshold for the health test (used only with the optional feature).

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
ena  input  1  design enable; low freezes all state
raw_bit  input  1  raw entropy bit from latch network
raw_valid  input  1  raw_bit qualifier, one bit consumed per high cycle
rd_req  input  1  read strobe from reader; pops the head byte
data_out  output  8  FIFO head byte
data_valid  output  1  FIFO non-empty
fifo_level  output  $clog2(FIFO_DEPTH)+1  entries held, 0..FIFO_DEPTH
overflow  output  1  sticky: a completed byte was dropped
health_fail  output  1  sticky health alarm (0 when feature is off)

Behaviour:
- Reset (async, rst_n=0): pair FSM to WAIT_A; bit count 0; shift register 0; FIFO empty; data_out=0, data_valid=0, fifo_level=0, overflow=0, health_fail=0.
- ena=0: raw_valid and rd_req ignored; all state held.
- Pair FSM, advancing only on ena & raw_valid:
  - WAIT_A: latch raw_bit as a, go to WAIT_B.
  - WAIT_B: compare raw_bit (b) with a, then go to WAIT_A.
  - a≠b: emit debiased bit = a (pair 10 gives 1, pair 01 gives 0).
  - a=b: emit nothing.
- Packing:
  - Each emitted bit updates the shift register: sr <= {sr[6:0], bit}. bit count increments modulo 8.
  - On the 8th bit, the byte {sr[6:0], bit} is written to the FIFO at that same edge, and bit count returns to 0.
  - The first emitted bit of a byte ends up in bit 7.
- FIFO:
  - Registered storage with wrapping read and write pointers.
  - data_out = mem[rd_ptr]; data_valid = (level≠0).
  - data_out is valid on the cycle after the write edge.
  - Pop: ena & rd_req & data_valid at a clock edge advances rd_ptr.
  - rd_req while empty is ignored; no underflow, level stays 0.
  - Push while full with no pop: byte dropped, overflow<=1 and held until reset, FIFO contents unchanged.
  - Push and pop in the same cycle: both occur and level is unchanged. This also holds when full, where it does not count as overflow.
- Pointers wrap at FIFO_DEPTH; fifo_level is exact.
- A reset mid-byte or mid-pair discards the partial byte and pair.

Optional Feature:
TTRNG_HEALTH_EN.
- Defined:
  - A repetition counter tracks consecutive identical raw bits, counting only raw_valid & ena cycles.
  - When the run length reaches RCT_LIMIT, health_fail<=1 (sticky until reset).
  - While health_fail=1, no bytes are pushed into the FIFO. Bytes already in the FIFO remain readable.
- Undefined: no counter is implemented, health_fail is tied to 0, and pushes are never blocked.

Test Plan:
- Feed raw pairs 10,01,10,10,01,01,01,10 with ena=1 (16 raw_valid cycles) -> data_valid=1 one cycle after the 16th edge, data_out=0xB1, fifo_level=1.
- Feed the same stream with pairs 00 and 11 interleaved -> still exactly one byte 0xB1.
- Push 5 bytes (0x01..0x05 via pair encoding) with no rd_req -> fifo_level=4, overflow=1, data_out=0x01. Four reads then return 0x01..0x04; a fifth rd_req while empty leaves level at 0.
- FIFO full while the 8th bit of a new byte arrives together with rd_req -> 0x01 popped, new byte written at the tail, level stays 4, overflow stays 0. With the FIFO empty, assert rd_req -> level stays 0, no underflow.
- Hold ena=0 while toggling raw_valid and rd_req -> state unchanged. Assert rst_n=0 after 5 debiased bits -> outputs 0; a subsequent 8-bit sequence yields the correct new byte.
- With TTRNG_HEALTH_EN: 32 consecutive raw 1s -> health_fail=1 on the 32nd edge; later valid pairs produce no pushes. Without the macro: health_fail stays 0.
